// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: sequences ROM addresses and MAC control for a 2-class fully-connected classifier,
// captures per-class scores, streams them out and produces an argmax prediction per sample.
module fc_seq_ctrl #(
    parameter int N_SAMPLES = 42,
    parameter int IN_DIM    = 16,
    parameter int ACC_W     = 36,
    parameter int RD_LAT    = 1,
    parameter int FEAT_AW   = 10,
    parameter int WGT_AW    = 5,
    localparam int SW = $clog2(N_SAMPLES + 1),
    localparam int KW = $clog2(IN_DIM + RD_LAT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [FEAT_AW-1:0]      feat_addr_o,
    output logic [WGT_AW-1:0]       wgt_addr_o,
    output logic                    mac_clr_o,
    output logic                    mac_en_o,
    output logic signed [ACC_W-1:0] out_wdata_o,
    output logic                    out_en_o,
    output logic                    pred_o,
    output logic                    pred_valid_o,
    output logic [SW-1:0]           sample_idx_o,
    output logic                    busy_o,
    output logic                    done_o
);
    typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, OUT0, OUT1, DONE} state_t;
    state_t                  state_q, state_d;
    logic [SW-1:0]           s_q, s_d;
    logic                    c_q, c_d;
    logic [KW-1:0]           k_q, k_d;
    logic [FEAT_AW-1:0]      feat_q, feat_d;
    logic [WGT_AW-1:0]       wgt_q, wgt_d;
    logic signed [ACC_W-1:0] sc0_q, sc0_d, sc1_q, sc1_d;
    logic                    pred_q;
    logic [RD_LAT-1:0]       en_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            feat_q  <= '0;
            wgt_q   <= '0;
            sc0_q   <= '0;
            sc1_q   <= '0;
            pred_q  <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            k_q     <= k_d;
            feat_q  <= feat_d;
            wgt_q   <= wgt_d;
            sc0_q   <= sc0_d;
            sc1_q   <= sc1_d;
            pred_q  <= pred_o;
            // MAC-cycle flag delayed to line up with ROM data at the MAC input
            en_q    <= (en_q << 1) | RD_LAT'(state_q == MAC);
        end
    end
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        k_d     = k_q;
        feat_d  = feat_q;
        wgt_d   = wgt_q;
        sc0_d   = sc0_q;
        sc1_d   = sc1_q;
        case (state_q)
            IDLE: if (start_i) begin
                s_d     = '0;
                c_d     = 1'b0;
                state_d = CLR;
            end
            CLR: begin
                k_d     = '0;
                feat_d  = FEAT_AW'(s_q) * FEAT_AW'(IN_DIM);
                wgt_d   = c_q ? WGT_AW'(IN_DIM) : '0;
                state_d = MAC;
            end
            MAC: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(IN_DIM - 1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    feat_d = feat_q + 1'b1;
                    wgt_d  = wgt_q + 1'b1;
                end
            end
            DRAIN: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(RD_LAT)) begin
                    sc0_d   = c_q ? sc0_q : acc_i;
                    sc1_d   = c_q ? acc_i : sc1_q;
                    c_d     = 1'b1;
                    state_d = c_q ? OUT0 : CLR;
                end
            end
            OUT0: state_d = OUT1;
            OUT1: begin
                c_d     = 1'b0;
                state_d = (s_q == SW'(N_SAMPLES - 1)) ? DONE : CLR;
                s_d     = (s_q == SW'(N_SAMPLES - 1)) ? s_q : s_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign feat_addr_o  = feat_q;
    assign wgt_addr_o   = wgt_q;
    assign mac_clr_o    = state_q == CLR;
    assign mac_en_o     = en_q[RD_LAT-1];
    assign out_en_o     = state_q == OUT0;
    assign out_wdata_o  = (state_q == OUT0) ? sc0_q : (state_q == OUT1) ? sc1_q : '0;
    assign pred_valid_o = state_q == OUT1;
    assign pred_o       = (state_q == OUT1) ? !(sc0_q > sc1_q) : pred_q;
    assign sample_idx_o = s_q;
    assign busy_o       = !(state_q == IDLE || state_q == DONE);
    assign done_o       = state_q == DONE;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: drives the sequencer against a behavioural ROM+MAC model and checks timing,
// addresses, scores and predictions for a small 3-sample, 4-term configuration.
module tb_fc_seq_ctrl;
    localparam int N = 3, D = 4, W = 36, L = 1, FA = 10, WA = 5, SW = 2;
    logic clk = 1'b0, rst_n_i = 1'b1, start_i = 1'b0;
    logic signed [W-1:0] acc_i;
    logic [FA-1:0] feat_addr_o;
    logic [WA-1:0] wgt_addr_o;
    logic mac_clr_o, mac_en_o, out_en_o, pred_o, pred_valid_o, busy_o, done_o;
    logic signed [W-1:0] out_wdata_o;
    logic [SW-1:0] sample_idx_o;

    fc_seq_ctrl #(.N_SAMPLES(N), .IN_DIM(D), .ACC_W(W), .RD_LAT(L), .FEAT_AW(FA), .WGT_AW(WA)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .acc_i(acc_i),
        .feat_addr_o(feat_addr_o), .wgt_addr_o(wgt_addr_o), .mac_clr_o(mac_clr_o),
        .mac_en_o(mac_en_o), .out_wdata_o(out_wdata_o), .out_en_o(out_en_o),
        .pred_o(pred_o), .pred_valid_o(pred_valid_o), .sample_idx_o(sample_idx_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int cyc = 0, t0 = -1000, clr_tot = 0, clr_base = 0, fj;
    int fr[1024];
    int wr[32];
    int rd_f = 0, rd_w = 0;
    logic force_m = 1'b0;
    logic signed [W-1:0] ftab[6];
    logic signed [W-1:0] emu_acc = '0;

    // ROM + MAC datapath model: one-cycle ROM read, accumulate on mac_en
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        clr_tot <= clr_tot + int'(mac_clr_o);
        rd_f    <= fr[feat_addr_o];
        rd_w    <= wr[wgt_addr_o];
        emu_acc <= mac_clr_o ? '0 : mac_en_o ? emu_acc + W'(rd_f * rd_w) : emu_acc;
    end

    always_comb begin
        fj    = clr_tot - clr_base - 1;
        acc_i = (force_m && fj >= 0 && fj < 6) ? ftab[fj] : emu_acc;
    end

    // per-run log indexed by cycles after the start edge (CLR of sample 0 is index 1)
    logic [FA-1:0] lf[80];
    logic [WA-1:0] lw[80];
    logic signed [W-1:0] lo[80];
    logic [SW-1:0] ls[80];
    logic le[80], lc[80], loe[80], lp[80], lpv[80], ld[80], lb[80];
    int n_oe = 0, n_done = 0;
    always @(negedge clk) begin : mon
        int i;
        i = cyc - t0 + 1;
        if (i >= 0 && i < 80) begin
            lf[i] = feat_addr_o; lw[i] = wgt_addr_o; lo[i] = out_wdata_o; ls[i] = sample_idx_o;
            le[i] = mac_en_o; lc[i] = mac_clr_o; loe[i] = out_en_o; lp[i] = pred_o;
            lpv[i] = pred_valid_o; ld[i] = done_o; lb[i] = busy_o;
        end
        n_oe   += int'(out_en_o);
        n_done += int'(done_o);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        @(posedge clk); #1;
        t0       = cyc + 1;
        clr_base = clr_tot;
        start_i  = 1'b1;
        wait_cyc(1);
        start_i  = 1'b0;
    endtask

    task automatic fill_roms();
        for (int i = 0; i < N * D; i++) fr[i] = int'($urandom_range(0, 15));
        for (int i = 0; i < 2 * D; i++) wr[i] = int'($urandom_range(0, 15)) - 8;
    endtask

    function automatic logic signed [W-1:0] ref_score(input int s, input int c);
        longint e = 0;
        for (int k = 0; k < D; k++) e += longint'(fr[s * D + k]) * longint'(wr[c * D + k]);
        return W'(e);
    endfunction

    task automatic test_reset();
        #3 rst_n_i = 1'b0;
        #1;
        total++;
        if ({busy_o, done_o, out_en_o, mac_en_o, mac_clr_o, pred_o, pred_valid_o, sample_idx_o, feat_addr_o, wgt_addr_o, out_wdata_o} !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b oe=%b en=%b clr=%b pred=%b pv=%b idx=%0d fa=%0d wa=%0d out=%0d want all 0",
                     busy_o, done_o, out_en_o, mac_en_o, mac_clr_o, pred_o, pred_valid_o, sample_idx_o, feat_addr_o, wgt_addr_o, out_wdata_o);
        else passed++;
        wait_cyc(3);
        rst_n_i = 1'b1;
        wait_cyc(3);
        total++;
        if (busy_o !== 1'b0 || mac_clr_o !== 1'b0) $display("FAIL idle_after_reset got busy=%b clr=%b want 0 0", busy_o, mac_clr_o);
        else passed++;
    endtask

    task automatic test_random_run();
        int c_oe = 0, c_pv = 0, c_d = 0;
        logic signed [W-1:0] e0, e1;
        fill_roms();
        force_m = 1'b0;
        run_start();
        wait_cyc(80);
        total++;
        if (lb[0] !== 1'b0 || lb[1] !== 1'b1) $display("FAIL busy_rise got %b%b want 01", lb[0], lb[1]);
        else passed++;
        for (int s = 0; s < N; s++) begin
            e0 = ref_score(s, 0);
            e1 = ref_score(s, 1);
            total++;
            if (loe[15 + 16 * s] !== 1'b1 || lo[15 + 16 * s] !== e0)
                $display("FAIL score0_s%0d got oe=%b val=%0d want oe=1 val=%0d", s, loe[15 + 16 * s], lo[15 + 16 * s], e0);
            else passed++;
            total++;
            if (loe[16 + 16 * s] !== 1'b0 || lo[16 + 16 * s] !== e1)
                $display("FAIL score1_s%0d got oe=%b val=%0d want oe=0 val=%0d", s, loe[16 + 16 * s], lo[16 + 16 * s], e1);
            else passed++;
            total++;
            if (lpv[16 + 16 * s] !== 1'b1 || lp[16 + 16 * s] !== (e0 > e1 ? 1'b0 : 1'b1) || ls[16 + 16 * s] !== SW'(s))
                $display("FAIL pred_s%0d got pv=%b pred=%b idx=%0d want pv=1 pred=%b idx=%0d",
                         s, lpv[16 + 16 * s], lp[16 + 16 * s], ls[16 + 16 * s], (e0 > e1 ? 1'b0 : 1'b1), s);
            else passed++;
        end
        for (int i = 0; i < 80; i++) begin
            c_oe += int'(loe[i]);
            c_pv += int'(lpv[i]);
            c_d  += int'(ld[i]);
        end
        total++;
        if (c_oe != N || c_pv != N) $display("FAIL pulse_counts got oe=%0d pv=%0d want %0d %0d", c_oe, c_pv, N, N);
        else passed++;
        total++;
        if (ld[49] !== 1'b1 || c_d != 1 || lb[49] !== 1'b0 || lb[48] !== 1'b1)
            $display("FAIL done_timing got done49=%b ndone=%0d busy48=%b busy49=%b want 1 1 1 0", ld[49], c_d, lb[48], lb[49]);
        else passed++;
    endtask

    task automatic test_addr_sweep();
        int ov = 0, ne = 0;
        fill_roms();
        force_m = 1'b0;
        run_start();
        wait_cyc(80);
        for (int k = 0; k < D; k++) begin
            total++;
            if (lf[25 + k] !== FA'(4 + k) || lw[25 + k] !== WA'(4 + k))
                $display("FAIL addr_s1c1_k%0d got feat=%0d wgt=%0d want %0d %0d", k, lf[25 + k], lw[25 + k], 4 + k, 4 + k);
            else passed++;
        end
        total++;
        if ({le[25], le[26], le[27], le[28], le[29], le[30]} !== 6'b011110)
            $display("FAIL mac_en_window got %b want 011110", {le[25], le[26], le[27], le[28], le[29], le[30]});
        else passed++;
        for (int i = 0; i < 80; i++) begin
            ov += int'(le[i] & lc[i]);
            ne += int'(le[i]);
        end
        total++;
        if (ov != 0 || ne != 2 * D * N) $display("FAIL mac_en_total got overlap=%0d en=%0d want 0 %0d", ov, ne, 2 * D * N);
        else passed++;
    endtask

    task automatic test_scores();
        logic exp_p[2][3];
        exp_p[0] = '{1'b0, 1'b1, 1'b1};
        exp_p[1] = '{1'b0, 1'b1, 1'b0};
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                ftab[0] = 100; ftab[1] = -20; ftab[2] = -5; ftab[3] = -5; ftab[4] = -7; ftab[5] = -3;
            end else begin
                ftab[0] = 36'h7_FFFF_FFFF; ftab[1] = 36'h8_0000_0000; ftab[2] = 0; ftab[3] = 0; ftab[4] = 5; ftab[5] = -5;
            end
            force_m = 1'b1;
            run_start();
            wait_cyc(80);
            force_m = 1'b0;
            for (int s = 0; s < N; s++) begin
                total++;
                if (loe[15 + 16 * s] !== 1'b1 || lo[15 + 16 * s] !== ftab[2 * s] || loe[16 + 16 * s] !== 1'b0 || lo[16 + 16 * s] !== ftab[2 * s + 1])
                    $display("FAIL fscore_r%0d_s%0d got %0d/%b %0d/%b want %0d/1 %0d/0", r, s, lo[15 + 16 * s], loe[15 + 16 * s],
                             lo[16 + 16 * s], loe[16 + 16 * s], ftab[2 * s], ftab[2 * s + 1]);
                else passed++;
                total++;
                if (lpv[16 + 16 * s] !== 1'b1 || lp[16 + 16 * s] !== exp_p[r][s])
                    $display("FAIL fpred_r%0d_s%0d got pv=%b pred=%b want pv=1 pred=%b", r, s, lpv[16 + 16 * s], lp[16 + 16 * s], exp_p[r][s]);
                else passed++;
            end
            total++;
            if (lp[17] !== exp_p[r][0] || lpv[17] !== 1'b0 || lo[17] !== '0)
                $display("FAIL pred_hold_r%0d got pred=%b pv=%b out=%0d want %b 0 0", r, lp[17], lpv[17], lo[17], exp_p[r][0]);
            else passed++;
        end
    endtask

    task automatic test_reset_midop();
        int oe0, d0;
        fill_roms();
        force_m = 1'b0;
        run_start();
        wait_cyc(25);
        #2 rst_n_i = 1'b0;
        #1;
        total++;
        if ({busy_o, mac_en_o, mac_clr_o, out_en_o, done_o, pred_o, pred_valid_o, sample_idx_o, feat_addr_o, wgt_addr_o, out_wdata_o} !== '0)
            $display("FAIL midop_reset got busy=%b en=%b idx=%0d fa=%0d wa=%0d want all 0", busy_o, mac_en_o, sample_idx_o, feat_addr_o, wgt_addr_o);
        else passed++;
        wait_cyc(3);
        rst_n_i = 1'b1;
        oe0 = n_oe;
        d0  = n_done;
        wait_cyc(60);
        total++;
        if (n_oe != oe0 || n_done != d0 || busy_o !== 1'b0)
            $display("FAIL post_reset_quiet got oe=%0d done=%0d busy=%b want 0 0 0", n_oe - oe0, n_done - d0, busy_o);
        else passed++;
        run_start();
        wait_cyc(80);
        total++;
        if (ls[15] !== '0 || lo[15] !== ref_score(0, 0) || lo[16] !== ref_score(0, 1) || ld[49] !== 1'b1)
            $display("FAIL restart_s0 got idx=%0d s0=%0d s1=%0d done=%b want 0 %0d %0d 1", ls[15], lo[15], lo[16], ld[49], ref_score(0, 0), ref_score(0, 1));
        else passed++;
    endtask

    task automatic test_start_ignored();
        int c_pv = 0, c_d = 0, c_b = 0;
        fill_roms();
        force_m = 1'b0;
        run_start();
        wait_cyc(2);
        start_i = 1'b1;
        wait_cyc(1);
        start_i = 1'b0;
        wait_cyc(45);
        start_i = 1'b1;
        wait_cyc(1);
        start_i = 1'b0;
        wait_cyc(32);
        for (int i = 0; i < 80; i++) begin
            c_pv += int'(lpv[i]);
            c_d  += int'(ld[i]);
            c_b  += (i >= 50) ? int'(lb[i]) : 0;
        end
        total++;
        if (c_pv != N || c_d != 1 || c_b != 0 || ld[49] !== 1'b1)
            $display("FAIL start_ignored got pv=%0d done=%0d busy_after=%0d done49=%b want %0d 1 0 1", c_pv, c_d, c_b, ld[49], N);
        else passed++;
        total++;
        if (lo[31] !== ref_score(1, 0) || lo[48] !== ref_score(2, 1))
            $display("FAIL start_ignored_scores got %0d %0d want %0d %0d", lo[31], lo[48], ref_score(1, 0), ref_score(2, 1));
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) fr[i] = 0;
        for (int i = 0; i < 32; i++) wr[i] = 0;
        for (int i = 0; i < 6; i++) ftab[i] = '0;
        test_reset();
        test_random_run();
        test_addr_sweep();
        test_scores();
        test_reset_midop();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
